// File: rtl/alu_pkg.sv
// Opcode/function encodings and datapath width shared by the execute-stage ALU.
package alu_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned CODE_W  = 6;

   localparam logic [CODE_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [CODE_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [CODE_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [CODE_W-1:0] OP_BLEZ  = 6'b000110;
   localparam logic [CODE_W-1:0] OP_BGTZ  = 6'b000111;
   localparam logic [CODE_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [CODE_W-1:0] OP_ADDIU = 6'b001001;
   localparam logic [CODE_W-1:0] OP_SLTI  = 6'b001010;
   localparam logic [CODE_W-1:0] OP_SLTIU = 6'b001011;
   localparam logic [CODE_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [CODE_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [CODE_W-1:0] OP_XORI  = 6'b001110;
   localparam logic [CODE_W-1:0] OP_LUI   = 6'b001111;
   localparam logic [CODE_W-1:0] OP_LW    = 6'b100011;
   localparam logic [CODE_W-1:0] OP_SW    = 6'b101011;

   localparam logic [CODE_W-1:0] FN_SLL  = 6'b000000;
   localparam logic [CODE_W-1:0] FN_SRL  = 6'b000010;
   localparam logic [CODE_W-1:0] FN_SRA  = 6'b000011;
   localparam logic [CODE_W-1:0] FN_SLLV = 6'b000100;
   localparam logic [CODE_W-1:0] FN_SRLV = 6'b000110;
   localparam logic [CODE_W-1:0] FN_SRAV = 6'b000111;
   localparam logic [CODE_W-1:0] FN_ADD  = 6'b100000;
   localparam logic [CODE_W-1:0] FN_ADDU = 6'b100001;
   localparam logic [CODE_W-1:0] FN_SUB  = 6'b100010;
   localparam logic [CODE_W-1:0] FN_SUBU = 6'b100011;
   localparam logic [CODE_W-1:0] FN_AND  = 6'b100100;
   localparam logic [CODE_W-1:0] FN_OR   = 6'b100101;
   localparam logic [CODE_W-1:0] FN_XOR  = 6'b100110;
   localparam logic [CODE_W-1:0] FN_NOR  = 6'b100111;
   localparam logic [CODE_W-1:0] FN_SLT  = 6'b101010;
   localparam logic [CODE_W-1:0] FN_SLTU = 6'b101011;

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit shifter: left, logical right, or arithmetic right.
module alu_shifter
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0]  data,
   input  logic [SHAMT_W-1:0] amount,
   input  logic               dir,
   input  logic               arith,
   output logic [DATA_W-1:0]  shifted_c
);

   // dir=1 shifts right; arith only matters for right shifts
   always_comb begin
      shifted_c = data << amount;
      if (dir) begin
         if (arith) shifted_c = DATA_W'($signed(data) >>> amount);
         else       shifted_c = data >> amount;
      end
   end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: decodes OPCODE/FUNC, computes result and branch flag, registers both.
module alu
   import alu_pkg::*;
(
   input  logic                CLK,
   input  logic                RST,
   input  logic [CODE_W-1:0]   OPCODE,
   input  logic [DATA_W-1:0]   RS_VAL,
   input  logic [DATA_W-1:0]   RT_VAL,
   input  logic [SHAMT_W-1:0]  SHAMT,
   input  logic [CODE_W-1:0]   FUNC,
   input  logic [IMM_W-1:0]    RAW_VAL,
   output logic [DATA_W-1:0]   RESULT,
   output logic                SIG_B
);

   logic [DATA_W-1:0]  sext_imm;
   logic [DATA_W-1:0]  zext_imm;
   logic [SHAMT_W-1:0] sh_amt;
   logic               sh_right;
   logic               sh_arith;
   logic [DATA_W-1:0]  sh_out;
   logic [DATA_W-1:0]  result_c;
   logic               sig_b_c;
   logic               rs_zero;

   assign sext_imm = {{(DATA_W-IMM_W){RAW_VAL[IMM_W-1]}}, RAW_VAL};
   assign zext_imm = {{(DATA_W-IMM_W){1'b0}}, RAW_VAL};
   assign rs_zero  = (RS_VAL == '0);

   // FUNC[2] picks variable amount, FUNC[1] right, FUNC[0] arithmetic
   assign sh_amt   = FUNC[2] ? RS_VAL[SHAMT_W-1:0] : SHAMT;
   assign sh_right = FUNC[1];
   assign sh_arith = FUNC[0];

   alu_shifter u_shifter (
      .data      (RT_VAL),
      .amount    (sh_amt),
      .dir       (sh_right),
      .arith     (sh_arith),
      .shifted_c (sh_out)
   );

   always_comb begin
      result_c = '0;
      sig_b_c  = 1'b0;
      case (OPCODE)
         OP_RTYPE: begin
            case (FUNC)
               FN_SLL, FN_SRL, FN_SRA,
               FN_SLLV, FN_SRLV, FN_SRAV: result_c = sh_out;
               FN_ADD, FN_ADDU:           result_c = RS_VAL + RT_VAL;
               FN_SUB, FN_SUBU:           result_c = RS_VAL - RT_VAL;
               FN_AND:                    result_c = RS_VAL & RT_VAL;
               FN_OR:                     result_c = RS_VAL | RT_VAL;
               FN_XOR:                    result_c = RS_VAL ^ RT_VAL;
               FN_NOR:                    result_c = ~(RS_VAL | RT_VAL);
               FN_SLT:  result_c = DATA_W'($signed(RS_VAL) < $signed(RT_VAL));
               FN_SLTU: result_c = DATA_W'(RS_VAL < RT_VAL);
               default:                   result_c = '0;
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_LW, OP_SW: result_c = RS_VAL + sext_imm;
         OP_SLTI:  result_c = DATA_W'($signed(RS_VAL) < $signed(sext_imm));
         OP_SLTIU: result_c = DATA_W'(RS_VAL < sext_imm);
         OP_ANDI:  result_c = RS_VAL & zext_imm;
         OP_ORI:   result_c = RS_VAL | zext_imm;
         OP_XORI:  result_c = RS_VAL ^ zext_imm;
         OP_LUI:   result_c = {RAW_VAL, {(DATA_W-IMM_W){1'b0}}};
         OP_BEQ:   sig_b_c  = (RS_VAL == RT_VAL);
         OP_BNE:   sig_b_c  = (RS_VAL != RT_VAL);
         OP_BLEZ:  sig_b_c  = RS_VAL[DATA_W-1] | rs_zero;
         OP_BGTZ:  sig_b_c  = ~RS_VAL[DATA_W-1] & ~rs_zero;
         default: begin
            result_c = '0;
            sig_b_c  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         RESULT <= '0;
         SIG_B  <= 1'b0;
      end else begin
         RESULT <= result_c;
         SIG_B  <= sig_b_c;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the execute-stage ALU with hand-computed expectations.
module tb_alu;

   logic        clk;
   logic        rst;
   logic [5:0]  opcode;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [4:0]  shamt;
   logic [5:0]  func;
   logic [15:0] raw_val;
   logic [31:0] result;
   logic        sig_b;

   int checks = 0;
   int errors = 0;

   alu dut (
      .CLK     (clk),
      .RST     (rst),
      .OPCODE  (opcode),
      .RS_VAL  (rs_val),
      .RT_VAL  (rt_val),
      .SHAMT   (shamt),
      .FUNC    (func),
      .RAW_VAL (raw_val),
      .RESULT  (result),
      .SIG_B   (sig_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] raw);
      opcode  = op;
      func    = fn;
      shamt   = sh;
      rs_val  = rs;
      rt_val  = rt;
      raw_val = raw;
   endtask

   task automatic run_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] raw, input logic [31:0] exp_res, input logic exp_b);
      drive(op, fn, sh, rs, rt, raw);
      @(posedge clk);
      #1;
      check_eq({tag, "_result"}, result, exp_res);
      check_eq({tag, "_sig_b"}, {31'b0, sig_b}, {31'b0, exp_b});
   endtask

   initial begin
      rst = 1'b1;
      drive(6'b000000, 6'b100000, 5'd0, 32'd7, 32'hFFFF_FFFD, 16'h0000);
      repeat (2) begin
         @(posedge clk);
         #1;
         check_eq("reset_result", result, 32'h0);
         check_eq("reset_sig_b", {31'b0, sig_b}, 32'h0);
      end
      rst = 1'b0;

      // SLL from the reference table
      run_op("sll_12", 6'b000000, 6'b000000, 5'd1, 32'd15, 32'd12, 16'h0, 32'd24, 1'b0);
      run_op("sll_22", 6'b000000, 6'b000000, 5'd1, 32'd23, 32'd22, 16'h0, 32'd44, 1'b0);
      run_op("sll_35", 6'b000000, 6'b000000, 5'd1, 32'd1,  32'd35, 16'h0, 32'd70, 1'b0);

      run_op("add",   6'b000000, 6'b100000, 5'd0, 32'd7, 32'hFFFF_FFFD, 16'h0, 32'd4, 1'b0);
      run_op("sub",   6'b000000, 6'b100010, 5'd0, 32'd0, 32'd1, 16'h0, 32'hFFFF_FFFF, 1'b0);
      run_op("slt",   6'b000000, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1, 16'h0, 32'd1, 1'b0);
      run_op("sltu",  6'b000000, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'd1, 16'h0, 32'd0, 1'b0);
      run_op("nor",   6'b000000, 6'b100111, 5'd0, 32'd0, 32'd0, 16'h0, 32'hFFFF_FFFF, 1'b0);
      run_op("and",   6'b000000, 6'b100100, 5'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 16'h0, 32'h00F0_1200, 1'b0);
      run_op("xor_eq", 6'b000000, 6'b100110, 5'd0, 32'd5, 32'd5, 16'h0, 32'd0, 1'b0);
      run_op("bad_fn", 6'b000000, 6'b111111, 5'd3, 32'd9, 32'd9, 16'h0, 32'd0, 1'b0);

      run_op("sra",    6'b000000, 6'b000011, 5'd4,  32'd0, 32'h8000_0000, 16'h0, 32'hF800_0000, 1'b0);
      run_op("srl",    6'b000000, 6'b000010, 5'd4,  32'd0, 32'h8000_0000, 16'h0, 32'h0800_0000, 1'b0);
      run_op("sra_31", 6'b000000, 6'b000011, 5'd31, 32'd0, 32'h8000_0000, 16'h0, 32'hFFFF_FFFF, 1'b0);
      run_op("sll_0",  6'b000000, 6'b000000, 5'd0,  32'd0, 32'hDEAD_BEEF, 16'h0, 32'hDEAD_BEEF, 1'b0);
      run_op("sllv",   6'b000000, 6'b000100, 5'd0,  32'd33, 32'd1, 16'h0, 32'd2, 1'b0);
      run_op("srav",   6'b000000, 6'b000111, 5'd0,  32'd4, 32'hF000_0000, 16'h0, 32'hFF00_0000, 1'b0);
      run_op("srlv",   6'b000000, 6'b000110, 5'd31, 32'd8, 32'hF000_0000, 16'h0, 32'h00F0_0000, 1'b0);

      run_op("addi",  6'b001000, 6'b0, 5'd0, 32'd10, 32'd0, 16'hFFFF, 32'd9, 1'b0);
      run_op("ori",   6'b001101, 6'b0, 5'd0, 32'd0,  32'd0, 16'h8000, 32'h0000_8000, 1'b0);
      run_op("lui",   6'b001111, 6'b0, 5'd0, 32'd77, 32'd0, 16'h1234, 32'h1234_0000, 1'b0);
      run_op("slti",  6'b001010, 6'b0, 5'd0, 32'hFFFF_FFFB, 32'd0, 16'hFFFE, 32'd1, 1'b0);
      run_op("sltiu", 6'b001011, 6'b0, 5'd0, 32'd5, 32'd0, 16'hFFFF, 32'd1, 1'b0);
      run_op("xori",  6'b001110, 6'b0, 5'd0, 32'hFFFF_0000, 32'd0, 16'hFFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("sw",    6'b101011, 6'b0, 5'd0, 32'd100, 32'd0, 16'hFFFC, 32'd96, 1'b0);
      run_op("lw",    6'b100011, 6'b0, 5'd0, 32'h1000, 32'd0, 16'h0010, 32'h1010, 1'b0);

      run_op("beq",     6'b000100, 6'b0, 5'd0, 32'd5, 32'd5, 16'h0, 32'd0, 1'b1);
      run_op("bne",     6'b000101, 6'b0, 5'd0, 32'd5, 32'd5, 16'h0, 32'd0, 1'b0);
      run_op("blez",    6'b000110, 6'b0, 5'd0, 32'd0, 32'd0, 16'h0, 32'd0, 1'b1);
      run_op("bgtz_n",  6'b000111, 6'b0, 5'd0, 32'hFFFF_FFFF, 32'd0, 16'h0, 32'd0, 1'b0);
      run_op("bgtz_p",  6'b000111, 6'b0, 5'd0, 32'd1, 32'd0, 16'h0, 32'd0, 1'b1);
      run_op("blez_p",  6'b000110, 6'b0, 5'd0, 32'd1, 32'd0, 16'h0, 32'd0, 1'b0);
      run_op("bad_op",  6'b111111, 6'b100000, 5'd0, 32'd3, 32'd3, 16'h1, 32'd0, 1'b0);

      // reset asserted mid-stream overrides a pending branch-taken result
      drive(6'b000100, 6'b0, 5'd0, 32'd8, 32'd8, 16'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("mid_rst_sig_b", {31'b0, sig_b}, 32'h0);
      rst = 1'b0;
      run_op("post_rst", 6'b000000, 6'b100000, 5'd0, 32'd7, 32'hFFFF_FFFD, 16'h0, 32'd4, 1'b0);
      drive(6'b000000, 6'b100000, 5'd0, 32'd7, 32'hFFFF_FFFD, 16'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("mid_rst_result", result, 32'h0);
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
